tpu_layer_scheduler: RTL and testbench
======================================

Name: tpu_layer_scheduler

Overview:
- Layer-level command scheduler in front of the ternary systolic array controller.
- Accepts layer descriptors (M/N/K plus a tag) over a valid/ready port and queues them.
- For each descriptor, in order: handshakes a bank prefetch with the DMA, pulses the controller's start, supervises the run with a timeout and abort, and reports tagged completion status plus cycle count.

Parameters:
- DEPTH, 4, descriptor FIFO entries (power of two, at least 2).
- ID_BITS, 4, width of the command tag.
- TIMEOUT_CYCLES, 65535, run cycles after ctl_start before status TIMEOUT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- cmd_valid  in  1  descriptor offered.
- cmd_ready  out  1  equals !fifo_full.
- cmd_rows / cmd_cols / cmd_k  in  16 each  layer M / N / K.
- cmd_id  in  ID_BITS  tag.
- pf_req  out  1  request prefetch into the shadow banks.
- pf_id  out  ID_BITS  tag of the prefetch.
- pf_ack  in  1  prefetch complete (single-cycle pulse).
- ctl_start  out  1  single-cycle start pulse to the controller.
- ctl_rows / ctl_cols / ctl_k  out  16 each  registered layer dimensions.
- ctl_done  in  1  controller done pulse.
- ctl_busy  in  1  controller busy.
- abort  in  1  abort the current command.
- cpl_valid  out  1  completion record valid.
- cpl_ready  in  1  completion record accepted.
- cpl_id  out  ID_BITS  tag of the completed command.
- cpl_status  out  2  0 OK, 1 TIMEOUT, 2 ABORTED, 3 BAD_DIM.
- cpl_cycles  out  32  cycles from ctl_start to done, saturating.
- busy  out  1  FSM not in S_IDLE, or FIFO not empty.
- queue_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: every registered output is 0. cmd_ready is 1 during and after reset. The FIFO is emptied.
- Push: occurs when cmd_valid && cmd_ready. No bypass: a pushed descriptor is visible at the FIFO head the next cycle. Push and pop in the same cycle leave queue_level unchanged.
- S_IDLE with FIFO not empty:
  - Head has rows, cols or k == 0: go to S_REPORT with BAD_DIM and cpl_cycles = 0. No pf_req, no ctl_start.
  - Otherwise: go to S_PREFETCH.
- S_PREFETCH:
  - pf_req = 1 and pf_id = head id, held until pf_ack.
  - pf_ack: go to S_LAUNCH.
  - abort without pf_ack: go to S_REPORT with ABORTED.
  - pf_ack and abort in the same cycle: pf_ack wins.
- S_LAUNCH:
  - Wait while ctl_busy = 1, so a previously abandoned controller run can drain.
  - When ctl_busy = 0: pulse ctl_start for exactly one cycle, latch ctl_rows/cols/k from the head, pop the FIFO, clear the cycle counter, go to S_RUN.
  - ctl_rows/cols/k stay stable until the next launch.
- S_RUN:
  - Cycle counter increments each cycle, saturating at 2^32-1.
  - ctl_done: go to S_REPORT with OK.
  - Counter == TIMEOUT_CYCLES: go to S_REPORT with TIMEOUT.
  - abort: go to S_REPORT with ABORTED.
  - Priority within a cycle: done > timeout > abort.
- Completion reporting:
  - On entry to S_REPORT, cpl_valid is registered high, with cpl_id/status/cycles stable, held until cpl_ready.
  - The transfer completes when cpl_valid && cpl_ready; the FSM returns to S_IDLE the next cycle.
  - The FIFO head is popped on entry to S_REPORT only if it was not already popped in S_LAUNCH (BAD_DIM and PREFETCH-abort cases).
- The block never resets the controller. After TIMEOUT or ABORTED, the next command stalls in S_LAUNCH until ctl_busy = 0.
- Every command is reported exactly once, in FIFO order.
- Latency floor from push to ctl_start is 4 cycles (push, IDLE, PREFETCH with same-cycle pf_ack, LAUNCH).
- Reset mid-operation returns everything to reset values. Queued commands are lost and no completion is emitted for them.

Decomposition:
- tpu_sched_pkg holds:
  - state_t enum: S_IDLE, S_PREFETCH, S_LAUNCH, S_RUN, S_REPORT.
  - sched_status_t enum: OK=0, TIMEOUT=1, ABORTED=2, BAD_DIM=3.
  - layer_desc_t packed struct: rows, cols, k, id.
- Sub-module tpu_desc_fifo: synchronous FIFO of layer_desc_t with full/empty/level and a registered-pointer memory. The top module holds the FSM, counters and completion register.

Test Plan:
- Single command (rows=16, cols=16, k=8, id=3); pf_ack 5 cycles after pf_req; ctl_done 40 cycles after ctl_start -> one ctl_start pulse with ctl_rows=16; completion id=3, status 0, cpl_cycles=40.
- Push 5 commands back to back with DEPTH=4 and pf_ack withheld -> cmd_ready drops after the 4th accept and queue_level=4; after acks, completions arrive in id order 0..4.
- Command with k=0, id=7 -> no pf_req, no ctl_start; completion status 3, cycles 0; the following valid command then launches normally.
- TIMEOUT_CYCLES=100, ctl_done never asserted, ctl_busy held high until cycle 150 -> status 1 at cycle 100; next command's ctl_start only after ctl_busy falls.
- abort in the same cycle as ctl_done -> status 0. abort during S_PREFETCH -> status 2, no ctl_start, pf_req deasserted the next cycle.
- cpl_ready held low 10 cycles while 2 commands are queued -> cpl fields stable; no new pf_req until the handshake completes; rst_n pulsed mid-S_RUN -> all outputs 0, queue_level 0.

Source files
------------

// File: rtl/tpu_sched_pkg.sv
// Shared types for the layer scheduler: FSM states, completion status and
// the queued layer descriptor.
package tpu_sched_pkg;

  localparam int unsigned DimBits   = 16;
  // The descriptor carries the widest supported tag; the top narrows it to ID_BITS.
  localparam int unsigned IdBitsMax = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_LAUNCH,
    S_RUN,
    S_REPORT
  } state_t;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    TIMEOUT = 2'd1,
    ABORTED = 2'd2,
    BAD_DIM = 2'd3
  } sched_status_t;

  typedef struct packed {
    logic [DimBits-1:0]   rows;
    logic [DimBits-1:0]   cols;
    logic [DimBits-1:0]   k;
    logic [IdBitsMax-1:0] id;
  } layer_desc_t;

  // A layer with any zero dimension cannot be run on the array.
  function automatic logic desc_bad_dim(layer_desc_t d);
    return (d.rows == '0) || (d.cols == '0) || (d.k == '0);
  endfunction

endpackage

// File: rtl/tpu_desc_fifo.sv
// Synchronous descriptor FIFO; head is read straight from memory at the read
// pointer, so a pushed entry is visible at the head on the following cycle.
module tpu_desc_fifo
  import tpu_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  layer_desc_t                wdata,
  input  logic                       pop,
  output layer_desc_t                rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wptr_q, rptr_q;
  layer_desc_t mem_q [DEPTH];
  logic        do_push, do_pop;

  assign level   = wptr_q - rptr_q;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pointed at by a valid entry.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tpu_layer_scheduler.sv
// Layer command scheduler: queues descriptors, then per command prefetches,
// launches the array controller, supervises the run and reports completion.
module tpu_layer_scheduler
  import tpu_sched_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned ID_BITS        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [15:0]               cmd_rows,
  input  logic [15:0]               cmd_cols,
  input  logic [15:0]               cmd_k,
  input  logic [ID_BITS-1:0]        cmd_id,
  output logic                      pf_req,
  output logic [ID_BITS-1:0]        pf_id,
  input  logic                      pf_ack,
  output logic                      ctl_start,
  output logic [15:0]               ctl_rows,
  output logic [15:0]               ctl_cols,
  output logic [15:0]               ctl_k,
  input  logic                      ctl_done,
  input  logic                      ctl_busy,
  input  logic                      abort,
  output logic                      cpl_valid,
  input  logic                      cpl_ready,
  output logic [ID_BITS-1:0]        cpl_id,
  output logic [1:0]                cpl_status,
  output logic [31:0]               cpl_cycles,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    queue_level
);

  layer_desc_t  wdata, head;
  logic         fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ID_BITS-1:0] head_id;

  state_t        state_q, state_d;
  logic [31:0]   cycles_q, cycles_d;
  logic          ctl_start_q, ctl_start_d;
  logic [15:0]   ctl_rows_q, ctl_rows_d, ctl_cols_q, ctl_cols_d, ctl_k_q, ctl_k_d;
  logic [ID_BITS-1:0] run_id_q, run_id_d;
  logic          cpl_valid_q, cpl_valid_d;
  logic [ID_BITS-1:0] cpl_id_q, cpl_id_d;
  sched_status_t cpl_status_q, cpl_status_d;
  logic [31:0]   cpl_cycles_q, cpl_cycles_d;

  assign wdata     = '{rows: cmd_rows, cols: cmd_cols, k: cmd_k, id: IdBitsMax'(cmd_id)};
  assign fifo_push = cmd_valid && cmd_ready;
  assign head_id   = head.id[ID_BITS-1:0];

  tpu_desc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (wdata),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (queue_level)
  );

  assign cmd_ready  = !fifo_full;
  assign pf_req     = (state_q == S_PREFETCH);
  assign pf_id      = pf_req ? head_id : '0;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign ctl_start  = ctl_start_q;
  assign ctl_rows   = ctl_rows_q;
  assign ctl_cols   = ctl_cols_q;
  assign ctl_k      = ctl_k_q;
  assign cpl_valid  = cpl_valid_q;
  assign cpl_id     = cpl_id_q;
  assign cpl_status = cpl_status_q;
  assign cpl_cycles = cpl_cycles_q;

  // Next-state, FIFO pop and completion record capture.
  always_comb begin
    state_d      = state_q;
    cycles_d     = cycles_q;
    ctl_start_d  = 1'b0;
    ctl_rows_d   = ctl_rows_q;
    ctl_cols_d   = ctl_cols_q;
    ctl_k_d      = ctl_k_q;
    run_id_d     = run_id_q;
    cpl_valid_d  = cpl_valid_q;
    cpl_id_d     = cpl_id_q;
    cpl_status_d = cpl_status_q;
    cpl_cycles_d = cpl_cycles_q;
    fifo_pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (desc_bad_dim(head)) begin
            // Never launched, so the head is retired here.
            fifo_pop     = 1'b1;
            cpl_valid_d  = 1'b1;
            cpl_id_d     = head_id;
            cpl_status_d = BAD_DIM;
            cpl_cycles_d = '0;
            state_d      = S_REPORT;
          end else begin
            state_d = S_PREFETCH;
          end
        end
      end
      S_PREFETCH: begin
        if (pf_ack) begin
          state_d = S_LAUNCH;
        end else if (abort) begin
          fifo_pop     = 1'b1;
          cpl_valid_d  = 1'b1;
          cpl_id_d     = head_id;
          cpl_status_d = ABORTED;
          cpl_cycles_d = '0;
          state_d      = S_REPORT;
        end
      end
      S_LAUNCH: begin
        // Hold off until an abandoned earlier run has drained from the controller.
        if (!ctl_busy) begin
          ctl_start_d = 1'b1;
          ctl_rows_d  = head.rows;
          ctl_cols_d  = head.cols;
          ctl_k_d     = head.k;
          run_id_d    = head_id;
          fifo_pop    = 1'b1;
          cycles_d    = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;
        if (ctl_done || (cycles_q == TIMEOUT_CYCLES) || abort) begin
          cpl_valid_d  = 1'b1;
          cpl_id_d     = run_id_q;
          cpl_cycles_d = cycles_q;
          state_d      = S_REPORT;
          if (ctl_done)                        cpl_status_d = OK;
          else if (cycles_q == TIMEOUT_CYCLES) cpl_status_d = TIMEOUT;
          else                                 cpl_status_d = ABORTED;
        end
      end
      S_REPORT: begin
        if (cpl_valid_q && cpl_ready) begin
          cpl_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cycles_q     <= '0;
      ctl_start_q  <= 1'b0;
      ctl_rows_q   <= '0;
      ctl_cols_q   <= '0;
      ctl_k_q      <= '0;
      run_id_q     <= '0;
      cpl_valid_q  <= 1'b0;
      cpl_id_q     <= '0;
      cpl_status_q <= OK;
      cpl_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      cycles_q     <= cycles_d;
      ctl_start_q  <= ctl_start_d;
      ctl_rows_q   <= ctl_rows_d;
      ctl_cols_q   <= ctl_cols_d;
      ctl_k_q      <= ctl_k_d;
      run_id_q     <= run_id_d;
      cpl_valid_q  <= cpl_valid_d;
      cpl_id_q     <= cpl_id_d;
      cpl_status_q <= cpl_status_d;
      cpl_cycles_q <= cpl_cycles_d;
    end
  end

endmodule

// File: tb/tb_tpu_layer_scheduler.sv
// Scoreboard bench: each issued command's expected completion is derived from
// its environment plan; DMA/controller models replay the plan, a monitor checks.
module tb_tpu_layer_scheduler;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ID_BITS = 4;
  localparam int          TMO     = 100;

  logic               clk, rst_n;
  logic               cmd_valid, cmd_ready;
  logic [15:0]        cmd_rows, cmd_cols, cmd_k;
  logic [ID_BITS-1:0] cmd_id;
  logic               pf_req, pf_ack;
  logic [ID_BITS-1:0] pf_id;
  logic               ctl_start, ctl_done, ctl_busy;
  logic [15:0]        ctl_rows, ctl_cols, ctl_k;
  logic               abort, abort_pf, abort_run;
  logic               cpl_valid, cpl_ready;
  logic [ID_BITS-1:0] cpl_id;
  logic [1:0]         cpl_status;
  logic [31:0]        cpl_cycles;
  logic               busy;
  logic [2:0]         queue_level;

  assign abort = abort_pf | abort_run;

  tpu_layer_scheduler #(
    .DEPTH          (DEPTH),
    .ID_BITS        (ID_BITS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rows    (cmd_rows),
    .cmd_cols    (cmd_cols),
    .cmd_k       (cmd_k),
    .cmd_id      (cmd_id),
    .pf_req      (pf_req),
    .pf_id       (pf_id),
    .pf_ack      (pf_ack),
    .ctl_start   (ctl_start),
    .ctl_rows    (ctl_rows),
    .ctl_cols    (ctl_cols),
    .ctl_k       (ctl_k),
    .ctl_done    (ctl_done),
    .ctl_busy    (ctl_busy),
    .abort       (abort),
    .cpl_valid   (cpl_valid),
    .cpl_ready   (cpl_ready),
    .cpl_id      (cpl_id),
    .cpl_status  (cpl_status),
    .cpl_cycles  (cpl_cycles),
    .busy        (busy),
    .queue_level (queue_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pf_kind: 0 ack, 1 abort, 2 ack+abort same cycle.
  // run_kind: 0 done at run_n, 1 abort at run_n, 2 done+abort at run_n, 3 never done.
  typedef struct {
    logic [15:0] rows, cols, k;
    int id, pf_delay, pf_kind, run_kind, run_n, linger;
  } plan_t;
  typedef struct { int id, status, cycles; } exp_t;

  plan_t pf_q[$];
  plan_t run_q[$];
  exp_t  exp_q[$];
  int    n_tests = 0, n_fail = 0;
  logic  pf_hold = 1'b0, cpl_hold = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: completion outcome straight from the scheduling rules.
  function automatic exp_t model(input plan_t p);
    exp_t e;
    e.id = p.id;
    if (p.rows == 0 || p.cols == 0 || p.k == 0) begin
      e.status = 3; e.cycles = 0;
    end else if (p.pf_kind == 1) begin
      e.status = 2; e.cycles = 0;
    end else if (p.run_kind == 3) begin
      e.status = 1; e.cycles = TMO;
    end else if (p.run_kind == 1) begin
      if (p.run_n < TMO) begin e.status = 2; e.cycles = p.run_n; end
      else begin e.status = 1; e.cycles = TMO; end
    end else begin
      if (p.run_n <= TMO) begin e.status = 0; e.cycles = p.run_n; end
      else begin e.status = 1; e.cycles = TMO; end
    end
    return e;
  endfunction

  function automatic plan_t mk(input int r, input int c, input int k, input int id,
                               input int pfd, input int pfk, input int rk, input int n,
                               input int lg);
    plan_t p;
    p.rows = 16'(r); p.cols = 16'(c); p.k = 16'(k); p.id = id;
    p.pf_delay = pfd; p.pf_kind = pfk; p.run_kind = rk; p.run_n = n; p.linger = lg;
    return p;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    int r;
    p.rows = ($urandom_range(0, 11) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
    p.cols = ($urandom_range(0, 11) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
    p.k    = ($urandom_range(0, 11) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
    p.id       = int'($urandom_range(0, 15));
    p.pf_delay = int'($urandom_range(0, 6));
    r = int'($urandom_range(0, 7));
    p.pf_kind  = (r == 0) ? 1 : (r == 1) ? 2 : 0;
    r = int'($urandom_range(0, 9));
    p.run_kind = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
    p.run_n    = int'($urandom_range(0, 60));
    p.linger   = int'($urandom_range(0, 20));
    return p;
  endfunction

  // Issue one command; the expected completion is recorded at issue time.
  task automatic push_cmd(input plan_t p);
    int n;
    exp_q.push_back(model(p));
    if (!(p.rows == 0 || p.cols == 0 || p.k == 0)) begin
      pf_q.push_back(p);
      if (p.pf_kind != 1) run_q.push_back(p);
    end
    cmd_valid = 1'b1;
    cmd_rows = p.rows; cmd_cols = p.cols; cmd_k = p.k; cmd_id = ID_BITS'(p.id);
    n = 0;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("cmd_accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n >= 8000) ? 1 : 0, 0);
  endtask

  // DMA model: answers each prefetch request according to its plan.
  initial begin : dma_model
    plan_t cur;
    int    cnt;
    logic  active, just_aborted;
    active = 1'b0; just_aborted = 1'b0; cnt = 0;
    pf_ack = 1'b0; abort_pf = 1'b0;
    forever begin
      @(negedge clk);
      pf_ack = 1'b0; abort_pf = 1'b0;
      if (!rst_n) begin
        active = 1'b0; just_aborted = 1'b0;
        continue;
      end
      if (just_aborted) begin
        check("pf_req_drop_after_abort", pf_req, 0);
        just_aborted = 1'b0;
      end
      if (pf_req && !active) begin
        if (pf_q.size() == 0) begin
          check("pf_req_unexpected", 1, 0);
        end else begin
          cur = pf_q.pop_front();
          active = 1'b1;
          cnt = cur.pf_delay;
          check("pf_id", pf_id, cur.id);
        end
      end
      if (active && !pf_hold) begin
        if (cnt == 0) begin
          if (cur.pf_kind != 1) pf_ack = 1'b1;
          if (cur.pf_kind != 0) abort_pf = 1'b1;
          just_aborted = (cur.pf_kind == 1);
          active = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Controller model: busy while running, lingers busy after an abandoned run.
  initial begin : ctl_model
    plan_t rp;
    int    k, linger;
    logic  active, prev_start, prev_busy, ends;
    active = 1'b0; prev_start = 1'b0; k = 0; linger = 0;
    ctl_done = 1'b0; abort_run = 1'b0; ctl_busy = 1'b0;
    forever begin
      @(negedge clk);
      prev_busy = ctl_busy;
      ctl_done = 1'b0; abort_run = 1'b0;
      if (!rst_n) begin
        active = 1'b0; linger = 0; ctl_busy = 1'b0; prev_start = 1'b0;
        continue;
      end
      if (ctl_start) begin
        check("start_while_busy", prev_busy, 0);
        check("start_single_cycle", prev_start, 0);
        if (run_q.size() == 0) begin
          check("ctl_start_unexpected", 1, 0);
        end else begin
          rp = run_q.pop_front();
          check("ctl_rows", ctl_rows, rp.rows);
          check("ctl_cols", ctl_cols, rp.cols);
          check("ctl_k", ctl_k, rp.k);
          active = 1'b1;
          k = 0;
        end
      end
      prev_start = ctl_start;
      if (active) begin
        ends = 1'b0;
        if (k == rp.run_n && rp.run_kind != 3) begin
          if (rp.run_kind != 1) ctl_done = 1'b1;
          if (rp.run_kind != 0) abort_run = 1'b1;
          ends = 1'b1;
        end
        if (k == TMO) ends = 1'b1;
        if (ends) begin
          active = 1'b0;
          linger = ctl_done ? 0 : rp.linger;
        end
        k++;
      end else if (linger > 0) begin
        linger--;
      end
      ctl_busy = active || (linger > 0);
    end
  end

  // Completion monitor: drives cpl_ready, checks stability and scoreboard order.
  initial begin : cpl_monitor
    exp_t e;
    logic stalled;
    logic [ID_BITS-1:0] s_id;
    logic [1:0] s_st;
    logic [31:0] s_cy;
    stalled = 1'b0; s_id = '0; s_st = '0; s_cy = '0;
    cpl_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0; cpl_ready = 1'b0;
        continue;
      end
      if (stalled) begin
        check("cpl_valid_held", cpl_valid, 1);
        check("cpl_id_stable", cpl_id, s_id);
        check("cpl_status_stable", cpl_status, s_st);
        check("cpl_cycles_stable", cpl_cycles, s_cy);
      end
      if (cpl_valid) check("pf_req_during_cpl", pf_req, 0);
      cpl_ready = cpl_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (cpl_valid && cpl_ready) begin
        if (exp_q.size() == 0) begin
          check("cpl_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("cpl_id", cpl_id, e.id);
          check("cpl_status", cpl_status, e.status);
          check("cpl_cycles", cpl_cycles, e.cycles);
        end
      end
      stalled = cpl_valid && !cpl_ready;
      s_id = cpl_id; s_st = cpl_status; s_cy = cpl_cycles;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_queue_level"}, queue_level, 0);
    check({tag, "_pf_req"}, pf_req, 0);
    check({tag, "_ctl_start"}, ctl_start, 0);
    check({tag, "_ctl_rows"}, ctl_rows, 0);
    check({tag, "_cpl_valid"}, cpl_valid, 0);
    check({tag, "_cpl_cycles"}, cpl_cycles, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0;
    cmd_rows = '0; cmd_cols = '0; cmd_k = '0; cmd_id = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single command with fixed timing.
    push_cmd(mk(16, 16, 8, 3, 5, 0, 0, 40, 0));
    wait_drain();

    // Fill the queue while the prefetch is held off.
    pf_hold = 1'b1;
    for (int i = 0; i < 4; i++) push_cmd(mk(8 + i, 4, 2, i, i, 0, 0, 5 + i, 0));
    check("full_cmd_ready", cmd_ready, 0);
    check("full_queue_level", queue_level, 4);
    fork
      push_cmd(mk(32, 32, 32, 4, 0, 0, 0, 3, 0));
      begin
        repeat (10) @(negedge clk);
        pf_hold = 1'b0;
      end
    join
    wait_drain();

    // Bad dimension, then a normal command.
    push_cmd(mk(4, 4, 0, 7, 0, 0, 0, 10, 0));
    push_cmd(mk(4, 4, 4, 8, 0, 0, 0, 10, 0));
    wait_drain();

    // Timeout with the controller staying busy until cycle 150.
    push_cmd(mk(2, 2, 2, 9, 1, 0, 3, 0, 50));
    push_cmd(mk(3, 3, 3, 10, 0, 0, 0, 7, 0));
    wait_drain();

    // Same-cycle priority cases and boundaries.
    push_cmd(mk(5, 5, 5, 11, 2, 0, 2, 20, 0));   // done + abort -> OK
    push_cmd(mk(5, 5, 5, 12, 3, 1, 0, 20, 0));   // abort in prefetch
    push_cmd(mk(5, 5, 5, 13, 0, 2, 0, 0, 0));    // ack + abort -> proceeds, done at 0
    push_cmd(mk(5, 5, 5, 14, 0, 0, 0, TMO, 0));  // done at timeout -> OK
    push_cmd(mk(5, 5, 5, 15, 0, 0, 1, TMO, 5));  // abort at timeout -> TIMEOUT
    push_cmd(mk(5, 5, 5, 1, 0, 0, 1, 0, 3));     // abort on start cycle
    wait_drain();

    // Completion back-pressure with commands queued behind it.
    cpl_hold = 1'b1;
    push_cmd(mk(6, 6, 6, 2, 0, 0, 0, 4, 0));
    push_cmd(mk(6, 6, 6, 5, 0, 0, 0, 4, 0));
    push_cmd(mk(6, 6, 6, 6, 0, 0, 0, 4, 0));
    repeat (30) @(negedge clk);
    cpl_hold = 1'b0;
    wait_drain();

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      push_cmd(rand_plan());
      n = int'($urandom_range(0, 30));
      repeat (n) @(negedge clk);
    end
    wait_drain();

    // Reset in the middle of a run with another command queued.
    push_cmd(mk(7, 7, 7, 3, 0, 0, 0, 80, 0));
    push_cmd(mk(7, 7, 7, 4, 0, 0, 0, 80, 0));
    n = 0;
    while (!ctl_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_start_seen", (n < 200) ? 1 : 0, 1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    pf_q.delete(); run_q.delete(); exp_q.delete();
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_reset_idle", busy, 0);
    push_cmd(mk(9, 9, 9, 12, 1, 0, 0, 12, 0));
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
